mrnaiso_seq: RTL and testbench

Clocked control-sequencer for the three-stage mRNA isolation array. It drives every pneumatic control line of the array through one full protocol: load cells, lyse, load beads, mix, separate, optionally wash, collect. It sits between the host command interface and the array's control inputs. All array stages share these control lines, and the block drives them as one set.

---
 rtl/mrnaiso_seq.sv | 250 +++++++++++++++++++++++++
 tb/tb_mrnaiso_seq.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/mrnaiso_seq.sv
// Control sequencer for the three-stage mRNA isolation array: load, lyse, beads, mix, separate, wash, collect.
// Optional WASH phase is built in when MRNAISO_SEQ_WASH_EN is defined; otherwise SEP goes straight to COLLECT.
module mrnaiso_seq #(
    parameter int T_LOAD     = 16,
    parameter int T_LYSE     = 32,
    parameter int T_BEADS    = 16,
    parameter int MIX_CYCLES = 4,
    parameter int PUMP_DIV   = 2,
    parameter int T_SEP      = 8,
    parameter int T_WASH     = 8,
    parameter int T_COLLECT  = 8,
    parameter int CNT_W      = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    output logic       busy,
    output logic       done,
    output logic       aborted,
    output logic [3:0] phase,
    output logic       cells_in_ctl,
    output logic       cells_out_ctl,
    output logic       collect_ctl,
    output logic       lysis_in_ctl,
    output logic       lysis_waste_ctl,
    output logic       beads_in_ctl,
    output logic       bead_waste_ctl,
    output logic       push_ctl,
    output logic       sep_ctl,
    output logic       sieve_ctl,
    output logic       waste_ctl,
    output logic       pump_1,
    output logic       pump_2,
    output logic       pump_3
);

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_LOAD    = 4'd1,
        S_LYSE    = 4'd2,
        S_BEADS   = 4'd3,
        S_MIX     = 4'd4,
        S_SEP     = 4'd5,
        S_WASH    = 4'd6,
        S_COLLECT = 4'd7,
        S_DONE    = 4'd8
    } state_t;

    // Zero-valued lengths behave as one so that every phase is at least one clock long.
    localparam int T_LOAD_E    = (T_LOAD     < 1) ? 1 : T_LOAD;
    localparam int T_LYSE_E    = (T_LYSE     < 1) ? 1 : T_LYSE;
    localparam int T_BEADS_E   = (T_BEADS    < 1) ? 1 : T_BEADS;
    localparam int T_SEP_E     = (T_SEP      < 1) ? 1 : T_SEP;
    localparam int T_WASH_E    = (T_WASH     < 1) ? 1 : T_WASH;
    localparam int T_COLLECT_E = (T_COLLECT  < 1) ? 1 : T_COLLECT;
    localparam int MIX_E       = (MIX_CYCLES < 1) ? 1 : MIX_CYCLES;
    localparam int PD_E        = (PUMP_DIV   < 1) ? 1 : PUMP_DIV;

    localparam logic [CNT_W-1:0] PD_LAST  = CNT_W'(PD_E - 1);
    localparam logic [CNT_W-1:0] MIX_LAST = CNT_W'(MIX_E - 1);

    // Valve vector bit order (1 = closed).
    localparam int V_CELLS_IN    = 10;
    localparam int V_CELLS_OUT   = 9;
    localparam int V_COLLECT     = 8;
    localparam int V_LYSIS_IN    = 7;
    localparam int V_LYSIS_WASTE = 6;
    localparam int V_BEADS_IN    = 5;
    localparam int V_BEAD_WASTE  = 4;
    localparam int V_PUSH        = 3;
    localparam int V_SEP         = 2;
    localparam int V_SIEVE       = 1;
    localparam int V_WASTE       = 0;

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] timer_reg, timer_next;
    logic [CNT_W-1:0] div_reg, div_next;
    logic [CNT_W-1:0] mix_reg, mix_next;
    logic [2:0]       step_reg, step_next;
    logic [10:0]      valve_reg, valve_next;
    logic [2:0]       pump_reg, pump_next;
    logic             busy_reg, busy_next;
    logic             done_reg, done_next;
    logic             aborted_reg, aborted_next;
    logic             expired, div_wrap, step_wrap;

    function automatic logic [CNT_W-1:0] timer_load(input state_t s);
        case (s)
            S_LOAD:    timer_load = CNT_W'(T_LOAD_E - 1);
            S_LYSE:    timer_load = CNT_W'(T_LYSE_E - 1);
            S_BEADS:   timer_load = CNT_W'(T_BEADS_E - 1);
            S_SEP:     timer_load = CNT_W'(T_SEP_E - 1);
            S_WASH:    timer_load = CNT_W'(T_WASH_E - 1);
            S_COLLECT: timer_load = CNT_W'(T_COLLECT_E - 1);
            default:   timer_load = '0;
        endcase
    endfunction

    function automatic logic [10:0] valve_pattern(input state_t s);
        logic [10:0] v;
        v = '1;
        case (s)
            S_LOAD: begin
                v[V_CELLS_IN]  = 1'b0;
                v[V_CELLS_OUT] = 1'b0;
                v[V_WASTE]     = 1'b0;
            end
            S_LYSE: begin
                v[V_LYSIS_IN]    = 1'b0;
                v[V_LYSIS_WASTE] = 1'b0;
            end
            S_BEADS: begin
                v[V_BEADS_IN]   = 1'b0;
                v[V_BEAD_WASTE] = 1'b0;
            end
            S_SEP: begin
                v[V_SEP]   = 1'b0;
                v[V_WASTE] = 1'b0;
            end
            S_WASH: begin
                v[V_PUSH]  = 1'b0;
                v[V_WASTE] = 1'b0;
            end
            S_COLLECT: begin
                v[V_PUSH]    = 1'b0;
                v[V_COLLECT] = 1'b0;
                v[V_SIEVE]   = 1'b0;
            end
            default: v = '1;
        endcase
        return v;
    endfunction

    function automatic logic [2:0] pump_pattern(input logic [2:0] step);
        case (step)
            3'd0:    pump_pattern = 3'b011;
            3'd1:    pump_pattern = 3'b001;
            3'd2:    pump_pattern = 3'b101;
            3'd3:    pump_pattern = 3'b100;
            3'd4:    pump_pattern = 3'b110;
            3'd5:    pump_pattern = 3'b010;
            default: pump_pattern = 3'b111;
        endcase
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= S_IDLE;
            timer_reg   <= '0;
            div_reg     <= '0;
            mix_reg     <= '0;
            step_reg    <= 3'd0;
            valve_reg   <= '1;
            pump_reg    <= 3'b111;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
            aborted_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            timer_reg   <= timer_next;
            div_reg     <= div_next;
            mix_reg     <= mix_next;
            step_reg    <= step_next;
            valve_reg   <= valve_next;
            pump_reg    <= pump_next;
            busy_reg    <= busy_next;
            done_reg    <= done_next;
            aborted_reg <= aborted_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        timer_next   = timer_reg;
        div_next     = div_reg;
        mix_next     = mix_reg;
        step_next    = step_reg;
        aborted_next = 1'b0;

        expired   = (timer_reg == '0);
        div_wrap  = (div_reg == PD_LAST);
        step_wrap = div_wrap && (step_reg == 3'd5);

        case (state_reg)
            S_IDLE:    if (start && !abort) state_next = S_LOAD;
            S_LOAD:    if (expired) state_next = S_LYSE;
            S_LYSE:    if (expired) state_next = S_BEADS;
            S_BEADS:   if (expired) state_next = S_MIX;
            S_MIX:     if (step_wrap && (mix_reg == MIX_LAST)) state_next = S_SEP;
`ifdef MRNAISO_SEQ_WASH_EN
            S_SEP:     if (expired) state_next = S_WASH;
`else
            S_SEP:     if (expired) state_next = S_COLLECT;
`endif
            S_WASH:    if (expired) state_next = S_COLLECT;
            S_COLLECT: if (expired) state_next = S_DONE;
            S_DONE:    state_next = S_IDLE;
            default:   state_next = S_IDLE;
        endcase

        // Abort beats any pending timer expiry.
        if (abort && (state_reg != S_IDLE)) begin
            state_next   = S_IDLE;
            aborted_next = 1'b1;
        end

        // Every state entry reloads the timer and restarts pump divider, step and wrap count.
        if (state_next != state_reg) begin
            timer_next = timer_load(state_next);
            div_next   = '0;
            step_next  = 3'd0;
            mix_next   = '0;
        end else begin
            if (!expired) timer_next = timer_reg - 1'b1;
            if (div_wrap) begin
                div_next  = '0;
                step_next = (step_reg == 3'd5) ? 3'd0 : step_reg + 3'd1;
                if (step_wrap) mix_next = mix_reg + 1'b1;
            end else begin
                div_next = div_reg + 1'b1;
            end
        end

        valve_next = valve_pattern(state_next);
        pump_next  = ((state_next == S_LYSE) || (state_next == S_MIX)) ? pump_pattern(step_next) : 3'b111;
        busy_next  = (state_next != S_IDLE);
        done_next  = (state_next == S_DONE);
    end

    assign phase           = state_reg;
    assign busy            = busy_reg;
    assign done            = done_reg;
    assign aborted         = aborted_reg;
    assign cells_in_ctl    = valve_reg[V_CELLS_IN];
    assign cells_out_ctl   = valve_reg[V_CELLS_OUT];
    assign collect_ctl     = valve_reg[V_COLLECT];
    assign lysis_in_ctl    = valve_reg[V_LYSIS_IN];
    assign lysis_waste_ctl = valve_reg[V_LYSIS_WASTE];
    assign beads_in_ctl    = valve_reg[V_BEADS_IN];
    assign bead_waste_ctl  = valve_reg[V_BEAD_WASTE];
    assign push_ctl        = valve_reg[V_PUSH];
    assign sep_ctl         = valve_reg[V_SEP];
    assign sieve_ctl       = valve_reg[V_SIEVE];
    assign waste_ctl       = valve_reg[V_WASTE];
    assign pump_1          = pump_reg[2];
    assign pump_2          = pump_reg[1];
    assign pump_3          = pump_reg[0];

endmodule

// File: tb/tb_mrnaiso_seq.sv
// Directed bench for mrnaiso_seq at default parameters; expectations follow MRNAISO_SEQ_WASH_EN if defined.
module tb_mrnaiso_seq;

    logic clk = 1'b0;
    logic rst, start, abort;
    logic busy, done, aborted;
    logic [3:0] phase;
    logic cells_in_ctl, cells_out_ctl, collect_ctl, lysis_in_ctl, lysis_waste_ctl;
    logic beads_in_ctl, bead_waste_ctl, push_ctl, sep_ctl, sieve_ctl, waste_ctl;
    logic pump_1, pump_2, pump_3;
    logic [10:0] valves;
    logic [2:0]  pump;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mrnaiso_seq dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .busy(busy), .done(done), .aborted(aborted), .phase(phase),
        .cells_in_ctl(cells_in_ctl), .cells_out_ctl(cells_out_ctl), .collect_ctl(collect_ctl),
        .lysis_in_ctl(lysis_in_ctl), .lysis_waste_ctl(lysis_waste_ctl),
        .beads_in_ctl(beads_in_ctl), .bead_waste_ctl(bead_waste_ctl),
        .push_ctl(push_ctl), .sep_ctl(sep_ctl), .sieve_ctl(sieve_ctl), .waste_ctl(waste_ctl),
        .pump_1(pump_1), .pump_2(pump_2), .pump_3(pump_3)
    );

    assign valves = {cells_in_ctl, cells_out_ctl, collect_ctl, lysis_in_ctl, lysis_waste_ctl,
                     beads_in_ctl, bead_waste_ctl, push_ctl, sep_ctl, sieve_ctl, waste_ctl};
    assign pump = {pump_1, pump_2, pump_3};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
        $display("check %-16s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Hand-written expectations: phase codes/lengths, valve patterns per phase, pump steps.
`ifdef MRNAISO_SEQ_WASH_EN
    localparam int NRUNS = 8;
    int exp_ph[8]  = '{1, 2, 3, 4, 5, 6, 7, 8};
    int exp_len[8] = '{16, 32, 16, 48, 8, 8, 8, 1};
    localparam int TOTAL = 136;
`else
    localparam int NRUNS = 7;
    int exp_ph[7]  = '{1, 2, 3, 4, 5, 7, 8};
    int exp_len[7] = '{16, 32, 16, 48, 8, 8, 1};
    localparam int TOTAL = 128;
`endif
    logic [10:0] exp_valve[9] = '{11'b11111111111, 11'b00111111110, 11'b11100111111,
                                  11'b11111001111, 11'b11111111111, 11'b11111111010,
                                  11'b11111110110, 11'b11011110101, 11'b11111111111};
    logic [2:0] pump_tab[6] = '{3'b011, 3'b001, 3'b101, 3'b100, 3'b110, 3'b010};

    logic [3:0]  ph_hist[400];
    logic [2:0]  pump_hist[400];
    logic [10:0] valve_hist[400];
    logic        done_hist[400];
    int run_ph[16], run_len[16], run_start[16];

    initial begin
        int c, nruns, ndone, done_idx, mix_done;
        rst = 1'b1; start = 1'b0; abort = 1'b0;
        tick(); tick();
        check("rst_phase", phase, 4'd0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_aborted", aborted, 1'b0);
        check("rst_valves", valves, 11'h7FF);
        check("rst_pump", pump, 3'b111);
        rst = 1'b0;
        tick();
        check("idle_hold", phase, 4'd0);

        // Full protocol, with start re-asserted during SEP and DONE.
        start = 1'b1;
        tick();
        start = 1'b0;
        check("load_phase", phase, 4'd1);
        check("load_busy", busy, 1'b1);
        check("load_valves", valves, 11'b00111111110);
        c = 0;
        while (c < 400 && phase != 4'd0) begin
            ph_hist[c] = phase; pump_hist[c] = pump; valve_hist[c] = valves; done_hist[c] = done;
            start = (phase == 4'd5) || (phase == 4'd8);
            tick();
            c++;
        end
        start = 1'b0;
        check("run_ends_idle", phase, 4'd0);
        tick();
        check("start_in_done_ign", phase, 4'd0);

        nruns = 0; ndone = 0; done_idx = -1;
        for (int i = 0; i < c; i++) begin
            if (i == 0 || ph_hist[i] != ph_hist[i-1]) begin
                if (nruns < 16) begin
                    run_ph[nruns] = ph_hist[i]; run_len[nruns] = 0; run_start[nruns] = i;
                end
                nruns++;
            end
            if (nruns <= 16) run_len[nruns-1]++;
            if (done_hist[i]) begin ndone++; done_idx = i; end
        end
        check("num_phases", nruns, NRUNS);
        for (int r = 0; r < NRUNS; r++) begin
            check($sformatf("run%0d_code", r), run_ph[r], exp_ph[r]);
            check($sformatf("run%0d_len", r), run_len[r], exp_len[r]);
            check($sformatf("run%0d_valves", r), valve_hist[run_start[r]], exp_valve[exp_ph[r]]);
        end
        check("done_count", ndone, 1);
        check("done_cycle", done_idx, TOTAL);
        for (int k = 0; k < 12; k++)
            check($sformatf("lyse_pump%0d", k), pump_hist[16 + k], pump_tab[(k / 2) % 6]);
        check("beads_pump", pump_hist[48], 3'b111);
        check("mix_pump_restart", pump_hist[64], 3'b011);
        check("mix_pump_last", pump_hist[111], 3'b010);

        // Abort in the 5th MIX cycle.
        start = 1'b1;
        tick();
        start = 1'b0;
        mix_done = 0;
        for (int i = 0; i < 200 && phase != 4'd4; i++) begin
            if (done) mix_done++;
            tick();
        end
        check("mix_reached", phase, 4'd4);
        for (int i = 0; i < 4; i++) tick();
        check("mix_5th", phase, 4'd4);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_phase", phase, 4'd0);
        check("abort_busy", busy, 1'b0);
        check("abort_pulse", aborted, 1'b1);
        check("abort_valves", valves, 11'h7FF);
        check("abort_pump", pump, 3'b111);
        check("abort_no_done", done + mix_done, 0);
        tick();
        check("abort_one_cycle", aborted, 1'b0);

        // Abort and start together in IDLE.
        start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        check("both_idle_phase", phase, 4'd0);
        check("both_idle_abort", aborted, 1'b0);

        // Abort on the last LOAD cycle wins over expiry.
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 15; i++) tick();
        check("load_last", phase, 4'd1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_prio_phase", phase, 4'd0);
        check("abort_prio_pulse", aborted, 1'b1);

        // Asynchronous reset in LYSE, between edges.
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 40 && phase != 4'd2; i++) tick();
        tick(); tick(); tick();
        check("lyse_reached", phase, 4'd2);
        #2;
        rst = 1'b1;
        #1;
        check("arst_phase", phase, 4'd0);
        check("arst_busy", busy, 1'b0);
        check("arst_valves", valves, 11'h7FF);
        check("arst_pump", pump, 3'b111);
        #1;
        rst = 1'b0;
        tick();
        check("arst_rel_phase", phase, 4'd0);
        check("arst_no_pulse", {done, aborted}, 2'b00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
